mod_halver_iter: RTL

Iterative modular halver: computes oData = iData · 2^(−k) mod iMod for odd iMod, one halving step per enabled clock. It is the inverse-direction companion of the registered modular doubler and undoes k doublings. It sits in the modular-arithmetic datapath as a multi-cycle unit with a start/valid handshake, for example as the final scaling stage after Montgomery-style accumulation.

---
 rtl/mod_arith_pkg.sv | 19 +
 rtl/mod_halver_iter_if.sv | 39 +++
 rtl/mod_halver.sv | 25 ++
 rtl/mod_halver_iter.sv | 112 +++++++++++
 4 files changed

// File: rtl/mod_arith_pkg.sv
// mod_arith_pkg: shared types and width helpers for the modular-arithmetic datapath.
//   state_e   - 2-bit FSM state encoding used by the iterative units (IDLE/RUN/DONE)
//   sum_width - width of an operand+modulus sum that keeps the carry out
package mod_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // One guard bit on top of the operand width holds the carry of acc + mod.
    localparam int unsigned SUM_GUARD_BITS = 1;

    function automatic int unsigned sum_width(input int unsigned bw);
        return bw + SUM_GUARD_BITS;
    endfunction

endpackage

// File: rtl/mod_halver_iter_if.sv
// mod_halver_iter_if: control/data bundle of the iterative modular halver.
//   iEn, iClr, iStart, iData, iMod, iShift - requests toward the halver
//   oBusy, oValid, oData                   - status and result from the halver
//   oErr (only with MOD_HALVER_ITER_CHECK_EN) - operand precondition flag
// Modports: master drives requests, slave is the halver side.
interface mod_halver_iter_if #(
    parameter int unsigned BITWIDTH = 32,
    parameter int unsigned CNTWIDTH = 6
);
    logic                iEn;
    logic                iClr;
    logic                iStart;
    logic [BITWIDTH-1:0] iData;
    logic [BITWIDTH-1:0] iMod;
    logic [CNTWIDTH-1:0] iShift;
    logic                oBusy;
    logic                oValid;
    logic [BITWIDTH-1:0] oData;
`ifdef MOD_HALVER_ITER_CHECK_EN
    logic                oErr;
`endif

    modport master (
        output iEn, iClr, iStart, iData, iMod, iShift,
`ifdef MOD_HALVER_ITER_CHECK_EN
        input  oErr,
`endif
        input  oBusy, oValid, oData
    );

    modport slave (
        input  iEn, iClr, iStart, iData, iMod, iShift,
`ifdef MOD_HALVER_ITER_CHECK_EN
        output oErr,
`endif
        output oBusy, oValid, oData
    );

endinterface

// File: rtl/mod_halver.sv
// mod_halver: one combinational modular halving step, x * 2^-1 mod m (m odd).
//   iData - operand, expected < iMod
//   iMod  - odd modulus
//   oData - (iData even) ? iData/2 : (iData + iMod)/2
module mod_halver
    import mod_arith_pkg::*;
#(
    parameter int unsigned BITWIDTH = 32
) (
    input  logic [BITWIDTH-1:0] iData,
    input  logic [BITWIDTH-1:0] iMod,
    output logic [BITWIDTH-1:0] oData
);

    localparam int unsigned SUMW = sum_width(BITWIDTH);

    logic [SUMW-1:0] sum_w;

    // An odd operand plus an odd modulus is even, so the shift is exact.
    always_comb begin
        sum_w = SUMW'(iData) + (iData[0] ? SUMW'(iMod) : '0);
        oData = BITWIDTH'(sum_w >> 1);
    end

endmodule

// File: rtl/mod_halver_iter.sv
// mod_halver_iter: iterative modular halver, oData = iData * 2^-k mod iMod.
//   iClk  - clock, rising edge
//   iRstN - asynchronous active-low reset
//   bus   - mod_halver_iter_if slave: iEn/iClr/iStart/iData/iMod/iShift in,
//           oBusy/oValid/oData (and oErr) out
// Optional feature macro: MOD_HALVER_ITER_CHECK_EN adds oErr, flagging an even
// modulus or an operand not below the modulus at start acceptance.
module mod_halver_iter
    import mod_arith_pkg::*;
#(
    parameter int unsigned BITWIDTH = 32,
    parameter int unsigned CNTWIDTH = 6
) (
    input logic                iClk,
    input logic                iRstN,
    mod_halver_iter_if.slave   bus
);

    state_e              state_q;
    logic [BITWIDTH-1:0] acc_q;
    logic [BITWIDTH-1:0] mod_q;
    logic [CNTWIDTH-1:0] cnt_q;
    logic                busy_q;
    logic                valid_q;
    logic [BITWIDTH-1:0] data_q;
    logic [BITWIDTH-1:0] acc_d;
`ifdef MOD_HALVER_ITER_CHECK_EN
    logic                err_q;
`endif

    mod_halver #(.BITWIDTH(BITWIDTH)) u_step (
        .iData (acc_q),
        .iMod  (mod_q),
        .oData (acc_d)
    );

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mod_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
`ifdef MOD_HALVER_ITER_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else if (bus.iClr) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
`ifdef MOD_HALVER_ITER_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else if (bus.iEn) begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (bus.iStart) begin
                        acc_q  <= bus.iData;
                        mod_q  <= bus.iMod;
                        cnt_q  <= bus.iShift;
                        busy_q <= 1'b1;
`ifdef MOD_HALVER_ITER_CHECK_EN
                        err_q  <= ~bus.iMod[0] | (bus.iData >= bus.iMod);
`endif
                        // k=0: result is the operand itself, presented in DONE.
                        if (bus.iShift != '0) begin
                            state_q <= RUN;
                        end else begin
                            state_q <= DONE;
                            valid_q <= 1'b1;
                            data_q  <= bus.iData;
                        end
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CNTWIDTH'(1);
                    // Output registers load on the final step so they are valid in DONE.
                    if (cnt_q == CNTWIDTH'(1)) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        data_q  <= acc_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oBusy  = busy_q;
    assign bus.oValid = valid_q;
    assign bus.oData  = data_q;
`ifdef MOD_HALVER_ITER_CHECK_EN
    assign bus.oErr   = err_q;
`endif

endmodule
